// File: rtl/msk_share_fifo.sv
// Elastic FIFO for masked words; every share is stored and moved on its own.
// Slot muxing uses pointers and handshakes only, never share values.
module msk_share_fifo #(
    parameter int d     = 2,
    parameter int count = 1,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [count*d-1:0]           in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [count*d-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int W  = count * d;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign in_ready  = (level != FULL);
    assign out_valid = (level != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case (1'b1)
                push && !pop: level <= level + LW'(1);
                pop && !push: level <= level - LW'(1);
                default: ;
            endcase
        end
    end

    // Popped slots are scrubbed so no stale share lingers at the read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (pop)  mem[rd_ptr] <= '0;
            if (push) mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_msk_share_fifo.sv
// Self-checking bench for msk_share_fifo (d=2, count=4, DEPTH=4).
// A queue model tracks contents; directed and random scenarios follow.
module tb_msk_share_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] level;

    int vectors = 0;
    int errors  = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    msk_share_fifo #(.d(2), .count(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level)
    );

    // One clock of stimulus; the queue model advances on the same edge.
    task automatic drive(input logic iv, input logic [7:0] id,
                         input logic ordy, input logic fl);
        bit p, pp;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        p  = iv && (q.size() < DEPTH);
        pp = ordy && (q.size() > 0);
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (pp) void'(q.pop_front());
            if (p) q.push_back(id);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if (out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vectors++;
        if (in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready); end
        vectors++;
        if (level !== 3'd0) begin errors++;
            $display("FAIL reset_level got %0d want 0", level); end
        vectors++;
        if (out_data !== 8'h00) begin errors++;
            $display("FAIL reset_out_data got %h want 00", out_data); end
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (level !== 3'd0 || out_valid !== 1'b0) begin errors++;
            $display("FAIL idle_after_reset got level=%0d ov=%b want 0 0",
                     level, out_valid); end
    endtask

    task automatic test_single_push();
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || level !== 3'd1) begin
            errors++;
            $display("FAIL single_push got ov=%b data=%h lvl=%0d want 1 a5 1",
                     out_valid, out_data, level); end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (level !== 3'd0 || out_data !== 8'h00 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop_scrub got lvl=%0d data=%h ov=%b want 0 00 0",
                     level, out_data, out_valid); end
    endtask

    task automatic test_fill();
        logic [7:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) drive(1'b1, words[i], 1'b0, 1'b0);
        vectors++;
        if (level !== 3'd4 || in_ready !== 1'b0) begin errors++;
            $display("FAIL fill_full got lvl=%0d ir=%b want 4 0", level, in_ready); end
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        vectors++;
        if (level !== 3'd4 || out_data !== 8'h11) begin errors++;
            $display("FAIL fill_drop got lvl=%0d data=%h want 4 11", level, out_data); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (out_data !== words[i] || out_valid !== 1'b1) begin errors++;
                $display("FAIL drain_%0d got %h ov=%b want %h 1",
                         i, out_data, out_valid, words[i]); end
            drive(1'b0, 8'h00, 1'b1, 1'b0);
        end
        vectors++;
        if (level !== 3'd0 || out_data !== 8'h00) begin errors++;
            $display("FAIL drain_empty got lvl=%0d data=%h want 0 00", level, out_data); end
    endtask

    task automatic test_stream_wrap();
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        for (int i = 2; i <= 10; i++) begin
            drive(1'b1, 8'(i), 1'b1, 1'b0);
            vectors++;
            if (level !== 3'd1 || out_data !== 8'(i)) begin errors++;
                $display("FAIL stream_%0d got lvl=%0d data=%h want 1 %h",
                         i, level, out_data, 8'(i)); end
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (level !== 3'd0 || out_data !== 8'h00) begin errors++;
            $display("FAIL stream_end got lvl=%0d data=%h want 0 00", level, out_data); end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) drive(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0);
        vectors++;
        if (in_ready !== 1'b0) begin errors++;
            $display("FAIL full_ir got %b want 0", in_ready); end
        drive(1'b1, 8'hEE, 1'b1, 1'b0);
        vectors++;
        if (level !== 3'd3 || in_ready !== 1'b1 || out_data !== 8'hB1) begin
            errors++;
            $display("FAIL full_pop got lvl=%0d ir=%b data=%h want 3 1 b1",
                     level, in_ready, out_data); end
        for (int i = 1; i < 4; i++) begin
            vectors++;
            if (out_data !== 8'hB0 + 8'(i)) begin errors++;
                $display("FAIL full_drain_%0d got %h want %h",
                         i, out_data, 8'hB0 + 8'(i)); end
            drive(1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    task automatic test_flush();
        logic [7:0] w;
        for (int i = 0; i < 3; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
        drive(1'b1, 8'h77, 1'b1, 1'b1);
        vectors++;
        if (level !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
            out_data !== 8'h00) begin errors++;
            $display("FAIL flush got lvl=%0d ov=%b ir=%b data=%h want 0 0 1 00",
                     level, out_valid, in_ready, out_data); end
        for (int i = 0; i < DEPTH; i++) begin
            w = 8'($urandom_range(1, 255));
            drive(1'b1, w, 1'b0, 1'b0);
            vectors++;
            if (out_data !== w) begin errors++;
                $display("FAIL probe_push_%0d got %h want %h", i, out_data, w); end
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            vectors++;
            if (out_data !== 8'h00 || out_valid !== 1'b0) begin errors++;
                $display("FAIL probe_zero_%0d got %h ov=%b want 00 0",
                         i, out_data, out_valid); end
        end
    endtask

    task automatic test_random();
        logic [7:0] ed;
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
            ed = (q.size() != 0) ? q[0] : 8'h00;
            vectors++;
            if (level !== 3'(q.size()) || out_valid !== (q.size() != 0) ||
                in_ready !== (q.size() != DEPTH) || out_data !== ed) begin
                errors++;
                $display("FAIL random_%0d got lvl=%0d ov=%b ir=%b data=%h want %0d %b %b %h",
                         n, level, out_valid, in_ready, out_data,
                         q.size(), q.size() != 0, q.size() != DEPTH, ed);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 8'h5A, 1'b0, 1'b0);
        drive(1'b1, 8'hC3, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || level !== 3'd0 ||
            in_ready !== 1'b1) begin errors++;
            $display("FAIL async_rst got ov=%b data=%h lvl=%0d ir=%b want 0 00 0 1",
                     out_valid, out_data, level, in_ready); end
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        drive(1'b1, 8'h3C, 1'b0, 1'b0);
        vectors++;
        if (out_data !== 8'h3C || level !== 3'd1) begin errors++;
            $display("FAIL post_rst got data=%h lvl=%0d want 3c 1", out_data, level); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_data = 8'h00; out_ready = 1'b0;
        test_reset();
        test_single_push();
        test_fill();
        test_stream_wrap();
        test_full_pop();
        test_flush();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
